// File: rtl/warships_pkg.sv
// rtl/warships_pkg.sv - shared constants, state encodings and cell helpers for the shot controller
package warships_pkg;

  localparam logic [7:0] NO_COR     = 8'hff;
  localparam int         GRID_N     = 10;
  localparam int         GRID_CELLS = GRID_N * GRID_N;
  localparam int         SHIP_CELLS = 20;
  localparam logic [3:0] GRID_N4    = 4'(GRID_N);

  typedef enum logic [2:0] {
    IDLE,
    AIM,
    SEND,
    WAIT,
    DONE
  } shot_state_t;

  typedef enum logic [1:0] {
    UNKNOWN = 2'b00,
    MISS    = 2'b01,
    HIT     = 2'b10,
    INVALID = 2'b11
  } cell_state_t;

  // both nibbles must address a real cell
  function automatic logic cor_valid(input logic [7:0] cor);
    return (cor[7:4] < GRID_N4) && (cor[3:0] < GRID_N4);
  endfunction

  // flat cell index x*GRID_N + y; meaningful only when cor_valid(cor)
  function automatic logic [6:0] cell_idx(input logic [7:0] cor);
    return 7'(cor[7:4]) * 7'(GRID_N) + 7'(cor[3:0]);
  endfunction

endpackage

// File: rtl/board_map.sv
// rtl/board_map.sv - enemy board shot/hit bitmaps with one write port and a registered query
module board_map (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [6:0] wr_idx,
  input  logic       wr_hit,
  input  logic [6:0] chk_idx,
  output logic       chk_shot,
  input  logic [7:0] query_cor,
  output logic [1:0] query_state
);
  import warships_pkg::*;

  logic [GRID_CELLS-1:0] shot_q, shot_d;
  logic [GRID_CELLS-1:0] hit_q, hit_d;
  cell_state_t           query_state_q, query_state_d;
  logic [6:0]            q_idx;

  // map update: clear wins over a write
  always_comb begin
    shot_d = shot_q;
    hit_d  = hit_q;
    if (clr) begin
      shot_d = '0;
      hit_d  = '0;
    end else if (wr_en) begin
      shot_d[wr_idx] = 1'b1;
      if (wr_hit) hit_d[wr_idx] = 1'b1;
    end
  end

  // query decode reads the maps before this cycle's write lands
  always_comb begin
    q_idx         = cell_idx(query_cor);
    query_state_d = UNKNOWN;
    if (!cor_valid(query_cor))  query_state_d = INVALID;
    else if (hit_q[q_idx])      query_state_d = HIT;
    else if (shot_q[q_idx])     query_state_d = MISS;
  end

  // map and query registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shot_q        <= '0;
      hit_q         <= '0;
      query_state_q <= UNKNOWN;
    end else begin
      shot_q        <= shot_d;
      hit_q         <= hit_d;
      query_state_q <= query_state_d;
    end
  end

  assign chk_shot    = shot_q[chk_idx];
  assign query_state = query_state_q;

endmodule

// File: rtl/shot_ctrl.sv
// rtl/shot_ctrl.sv - turns enemy-board clicks into one-shot fire requests and tracks hits to a win
module shot_ctrl #(
  parameter int RESULT_TIMEOUT = 1_000_000,
  parameter int SHIP_CELLS     = warships_pkg::SHIP_CELLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [7:0] enemy_cor,
  input  logic       my_turn,
  output logic [7:0] shot_cor,
  output logic       shot_valid,
  input  logic       shot_ready,
  input  logic       result_valid,
  input  logic       result_hit,
  output logic       click_reject,
  output logic [6:0] shots_fired,
  output logic [4:0] hits,
  output logic       win,
  output logic       busy,
  input  logic [7:0] query_cor,
  output logic [1:0] query_state
);
  import warships_pkg::*;

  localparam int TW = $clog2(RESULT_TIMEOUT + 1);

  shot_state_t state_q, state_d;
  logic        start_prev_q, start_prev_d;
  logic        start_rise_q, start_rise_d;
  logic        click_q, click_d;
  logic [7:0]  cor_prev_q, cor_prev_d;
  logic [7:0]  shot_cor_q, shot_cor_d;
  logic        shot_valid_q, shot_valid_d;
  logic        click_reject_q, click_reject_d;
  logic [6:0]  shots_fired_q, shots_fired_d;
  logic [4:0]  hits_q, hits_d;
  logic        win_q, win_d;
  logic        busy_q, busy_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        map_clr, map_wr, map_hit, aim_shot;

  board_map u_map (
    .clk         (clk),
    .rst         (rst),
    .clr         (map_clr),
    .wr_en       (map_wr),
    .wr_idx      (cell_idx(shot_cor_q)),
    .wr_hit      (map_hit),
    .chk_idx     (cell_idx(cor_prev_q)),
    .chk_shot    (aim_shot),
    .query_cor   (query_cor),
    .query_state (query_state)
  );

  // edge detection and game FSM next-state; the clicked coordinate is cor_prev_q when click_q is high
  always_comb begin
    state_d        = state_q;
    start_prev_d   = start_btn;
    start_rise_d   = start_btn & ~start_prev_q;
    cor_prev_d     = enemy_cor;
    click_d        = (enemy_cor != NO_COR) && (cor_prev_q == NO_COR);
    shot_cor_d     = shot_cor_q;
    click_reject_d = 1'b0;
    shots_fired_d  = shots_fired_q;
    hits_d         = hits_q;
    tmo_d          = tmo_q;
    map_clr        = 1'b0;
    map_wr         = 1'b0;
    map_hit        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise_q) begin
          state_d    = AIM;
          shot_cor_d = NO_COR;
        end
      end
      AIM: begin
        if (click_q) begin
          if (my_turn && cor_valid(cor_prev_q) && !aim_shot) begin
            shot_cor_d = cor_prev_q;
            state_d    = SEND;
          end else begin
            click_reject_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (shot_valid_q && shot_ready) begin
          state_d = WAIT;
          tmo_d   = '0;
        end
      end
      WAIT: begin
        if (result_valid) begin
          map_wr        = 1'b1;
          map_hit       = result_hit;
          shots_fired_d = (shots_fired_q == 7'd100) ? shots_fired_q : shots_fired_q + 7'd1;
          hits_d        = hits_q + 5'(result_hit);
          if (hits_d == 5'(SHIP_CELLS)) begin
            state_d = DONE;
          end else begin
            state_d    = AIM;
            shot_cor_d = NO_COR;
          end
        end else if (tmo_q == TW'(RESULT_TIMEOUT - 1)) begin
          state_d = SEND;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE: begin
        if (start_rise_q) begin
          map_clr       = 1'b1;
          shots_fired_d = '0;
          hits_d        = '0;
          state_d       = AIM;
          shot_cor_d    = NO_COR;
        end
      end
      default: state_d = IDLE;
    endcase
    shot_valid_d = (state_d == SEND);
    busy_d       = (state_d == SEND) || (state_d == WAIT);
    win_d        = (state_d == DONE);
  end

  // single state/output register bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      start_prev_q   <= 1'b0;
      start_rise_q   <= 1'b0;
      click_q        <= 1'b0;
      cor_prev_q     <= NO_COR;
      shot_cor_q     <= NO_COR;
      shot_valid_q   <= 1'b0;
      click_reject_q <= 1'b0;
      shots_fired_q  <= '0;
      hits_q         <= '0;
      win_q          <= 1'b0;
      busy_q         <= 1'b0;
      tmo_q          <= '0;
    end else begin
      state_q        <= state_d;
      start_prev_q   <= start_prev_d;
      start_rise_q   <= start_rise_d;
      click_q        <= click_d;
      cor_prev_q     <= cor_prev_d;
      shot_cor_q     <= shot_cor_d;
      shot_valid_q   <= shot_valid_d;
      click_reject_q <= click_reject_d;
      shots_fired_q  <= shots_fired_d;
      hits_q         <= hits_d;
      win_q          <= win_d;
      busy_q         <= busy_d;
      tmo_q          <= tmo_d;
    end
  end

  assign shot_cor     = shot_cor_q;
  assign shot_valid   = shot_valid_q;
  assign click_reject = click_reject_q;
  assign shots_fired  = shots_fired_q;
  assign hits         = hits_q;
  assign win          = win_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_shot_ctrl.sv
// tb/tb_shot_ctrl.sv - directed scoreboard bench for shot_ctrl
module tb_shot_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic [7:0] enemy_cor;
  logic       my_turn;
  logic [7:0] shot_cor;
  logic       shot_valid;
  logic       shot_ready;
  logic       result_valid;
  logic       result_hit;
  logic       click_reject;
  logic [6:0] shots_fired;
  logic [4:0] hits;
  logic       win;
  logic       busy;
  logic [7:0] query_cor;
  logic [1:0] query_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] shot_exp_q[$];
  logic [1:0] qry_exp_q[$];

  shot_ctrl #(.RESULT_TIMEOUT(16), .SHIP_CELLS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_btn    (start_btn),
    .enemy_cor    (enemy_cor),
    .my_turn      (my_turn),
    .shot_cor     (shot_cor),
    .shot_valid   (shot_valid),
    .shot_ready   (shot_ready),
    .result_valid (result_valid),
    .result_hit   (result_hit),
    .click_reject (click_reject),
    .shots_fired  (shots_fired),
    .hits         (hits),
    .win          (win),
    .busy         (busy),
    .query_cor    (query_cor),
    .query_state  (query_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected shot request pushed with the click, popped when shot_valid appears
  task automatic fire_click(input logic [7:0] cor);
    logic [7:0] e;
    shot_exp_q.push_back(cor);
    enemy_cor = cor;
    tick();
    chk("shot_valid_early", shot_valid, 1'b0);
    tick();
    chk("shot_valid_up", shot_valid, 1'b1);
    chk("busy_send", busy, 1'b1);
    e = shot_exp_q.pop_front();
    chk("shot_cor", shot_cor, e);
    enemy_cor = 8'hff;
  endtask

  task automatic accept_shot();
    shot_ready = 1'b1;
    tick();
    shot_ready = 1'b0;
    chk("wait_valid_low", shot_valid, 1'b0);
    chk("wait_busy", busy, 1'b1);
  endtask

  task automatic give_result(input logic hit);
    result_valid = 1'b1;
    result_hit   = hit;
    tick();
    result_valid = 1'b0;
    result_hit   = 1'b0;
  endtask

  task automatic query(input logic [7:0] cor, input logic [1:0] exp);
    logic [1:0] e;
    qry_exp_q.push_back(exp);
    query_cor = cor;
    tick();
    e = qry_exp_q.pop_front();
    chk("query_state", query_state, e);
  endtask

  task automatic click_rejected(input logic [7:0] cor, input logic turn);
    my_turn   = turn;
    enemy_cor = cor;
    tick();
    chk("reject_early", click_reject, 1'b0);
    tick();
    chk("reject_pulse", click_reject, 1'b1);
    chk("reject_no_shot", shot_valid, 1'b0);
    tick();
    chk("reject_one_cycle", click_reject, 1'b0);
    enemy_cor = 8'hff;
    tick();
    my_turn = 1'b1;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    tick();
    tick();
    start_btn = 1'b0;
    tick();
  endtask

  initial begin
    int rises;
    logic prev_v;
    logic [7:0] e;
    rst          = 1'b1;
    start_btn    = 1'b0;
    enemy_cor    = 8'hff;
    my_turn      = 1'b0;
    shot_ready   = 1'b0;
    result_valid = 1'b0;
    result_hit   = 1'b0;
    query_cor    = 8'h00;
    #3;
    chk("rst_shot_cor", shot_cor, 8'hff);
    chk("rst_shot_valid", shot_valid, 1'b0);
    chk("rst_click_reject", click_reject, 1'b0);
    chk("rst_shots_fired", shots_fired, 7'd0);
    chk("rst_hits", hits, 5'd0);
    chk("rst_win", win, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_query", query_state, 2'b00);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // click before start is ignored
    my_turn   = 1'b1;
    enemy_cor = 8'h11;
    tick();
    tick();
    chk("idle_no_reject", click_reject, 1'b0);
    chk("idle_no_shot", shot_valid, 1'b0);
    enemy_cor = 8'hff;
    tick();

    press_start();
    chk("aim_not_busy", busy, 1'b0);

    // first shot, held off by shot_ready
    fire_click(8'h34);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", shot_valid, 1'b1);
      chk("hold_cor", shot_cor, 8'h34);
    end
    accept_shot();
    give_result(1'b1);
    chk("hit1_hits", hits, 5'd1);
    chk("hit1_fired", shots_fired, 7'd1);
    chk("hit1_aim", busy, 1'b0);
    chk("hit1_cor_idle", shot_cor, 8'hff);
    chk("hit1_no_win", win, 1'b0);
    query(8'h34, 2'b10);
    query(8'h35, 2'b00);
    query(8'hA0, 2'b11);

    // refused clicks
    click_rejected(8'h34, 1'b1);
    click_rejected(8'h3A, 1'b1);
    click_rejected(8'h22, 1'b0);

    // held button: exactly one request
    rises     = 0;
    prev_v    = 1'b0;
    shot_exp_q.push_back(8'h12);
    enemy_cor = 8'h12;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (shot_valid && !prev_v) begin
        rises++;
        e = shot_exp_q.pop_front();
        chk("held_cor", shot_cor, e);
      end
      prev_v = shot_valid;
    end
    chk("held_one_request", rises, 1);
    enemy_cor = 8'hff;
    tick();
    accept_shot();
    enemy_cor = 8'h55;
    tick();
    chk("wait_click_ignored", click_reject, 1'b0);
    tick();
    chk("wait_click_ignored2", click_reject, 1'b0);
    chk("wait_still_busy", busy, 1'b1);
    enemy_cor = 8'hff;
    tick();
    give_result(1'b0);
    chk("miss_hits", hits, 5'd1);
    chk("miss_fired", shots_fired, 7'd2);
    chk("miss_aim", busy, 1'b0);
    query(8'h12, 2'b01);
    query(8'h55, 2'b00);

    // result timeout re-send
    fire_click(8'h56);
    accept_shot();
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("tmo_quiet", shot_valid, 1'b0);
    end
    shot_exp_q.push_back(8'h56);
    tick();
    chk("tmo_resend", shot_valid, 1'b1);
    e = shot_exp_q.pop_front();
    chk("tmo_resend_cor", shot_cor, e);
    accept_shot();
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("tmo2_quiet", shot_valid, 1'b0);
    end
    give_result(1'b0);
    chk("expiry_result_no_resend", shot_valid, 1'b0);
    chk("expiry_result_aim", busy, 1'b0);
    chk("expiry_fired", shots_fired, 7'd3);
    tick();
    chk("expiry_still_quiet", shot_valid, 1'b0);
    query(8'h56, 2'b01);

    // winning hit
    fire_click(8'h77);
    accept_shot();
    give_result(1'b1);
    chk("win_flag", win, 1'b1);
    chk("win_hits", hits, 5'd2);
    chk("win_fired", shots_fired, 7'd4);
    chk("win_not_busy", busy, 1'b0);
    query(8'h77, 2'b10);
    enemy_cor = 8'h88;
    tick();
    tick();
    chk("done_click_ignored", click_reject, 1'b0);
    chk("done_no_shot", shot_valid, 1'b0);
    enemy_cor = 8'hff;
    tick();

    // restart clears the game
    press_start();
    chk("restart_win", win, 1'b0);
    chk("restart_hits", hits, 5'd0);
    chk("restart_fired", shots_fired, 7'd0);
    chk("restart_cor", shot_cor, 8'hff);
    for (int x = 0; x < 10; x++) begin
      for (int y = 0; y < 10; y++) begin
        query({4'(x), 4'(y)}, 2'b00);
      end
    end

    // async reset during SEND
    fire_click(8'h90);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", shot_valid, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_cor", shot_cor, 8'hff);
    #1;
    rst = 1'b0;
    tick();

    chk("shot_sb_empty", shot_exp_q.size(), 0);
    chk("query_sb_empty", qry_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
